muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide engine and HI/LO register owner for the pipelined MIPS core. It sits beside the execute-stage ALU. Decode issues MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO requests to it. The unit runs a shift-add or restoring-divide sequence over WIDTH cycles and drives `stall` to freeze fetch/decode whenever an instruction needs HI/LO, or a new operation, while the engine is busy.

## Interface

Parameters:
- WIDTH, 32: operand width; iteration count equals WIDTH; counter is $clog2(WIDTH) bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- md_start  in  1  decode presents a multiply/divide this cycle.
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_a  in  WIDTH  rs value (multiplicand / dividend).
- md_b  in  WIDTH  rt value (multiplier / divisor).
- mf_req  in  1  decode presents MFHI or MFLO this cycle.
- mt_hi  in  1  write `mt_data` to HI.
- mt_lo  in  1  write `mt_data` to LO.
- mt_data  in  WIDTH  rs value for MTHI/MTLO.
- hi  out  WIDTH  HI register (product high half / remainder).
- lo  out  WIDTH  LO register (product low half / quotient).
- busy  out  1  engine not IDLE.
- stall  out  1  combinational: busy & (md_start | mf_req | mt_hi | mt_lo).

## Operation

- States: IDLE, ITER, FIX.
- IDLE:
  - On md_start, latch |md_a| and |md_b| (magnitude for signed ops, raw for unsigned), result sign, remainder sign, and op.
  - Clear the accumulator and set count = 0. Go to ITER.
- ITER:
  - Multiply: one shift-add step per cycle on a 2×WIDTH accumulator.
  - Divide: one restoring step per cycle (shift remainder left, trial-subtract divisor, set quotient bit when non-negative).
  - count increments each cycle. When count == WIDTH-1, go to FIX.
- FIX:
  - Apply sign correction and write hi/lo. Go to IDLE.
  - MULT: two's-complement negate the 2×WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero, any signedness: lo = all-ones, hi = md_a (raw, uncorrected).
- Signed overflow, DIV with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MTHI/MTLO:
  - Honoured only in IDLE; the register is written on the next edge.
  - mt_hi and mt_lo together write both registers.
  - md_start in the same cycle takes priority and the mt write is dropped.
- Requests while busy are not accepted. `stall` holds decode and the request is re-presented unchanged.
- MFHI/MFLO read `hi`/`lo` directly; there is no read port logic. Issue is legal whenever stall = 0.
- hi/lo are untouched from accept until FIX, so they keep their old values during ITER.

## Timing

- Reset (async, immediate): state IDLE, count 0, hi = 0, lo = 0, busy = 0, stall = 0 regardless of inputs.
- Accept edge E0, with md_start high in IDLE: busy = 1 from after E0.
- ITER occupies edges E1..E32 (WIDTH = 32). FIX occurs at edge E33.
- hi/lo are valid and busy = 0 after E33. Total latency is WIDTH + 1 cycles after accept.
- Back-to-back: an md_start held during the stall is accepted on the first IDLE cycle, i.e. edge E34.
- No restart mid-operation. Only rst aborts, and an abort leaves hi = lo = 0.
- stall is purely combinational from busy and the request inputs, with no registered delay, so decode freezes in the same cycle.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF at E0 → after E33: hi = 0xFFFFFFFE, lo = 0x00000001; busy high for exactly 33 cycles.
- MULT −3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 9 / 0 → lo = 0xFFFFFFFF, hi = 9.
- Start DIVU 100 / 7, then hold mf_req high from E1:
  - stall = 1 through the cycle before E33, and 0 after; hi = 2, lo = 14.
  - A second md_start held during busy is accepted at E34.
  - MTLO 0x1234 in IDLE → lo = 0x1234 next cycle.
- Assert rst at E10 of a MULT → hi = lo = 0, busy = 0 immediately; a new MULTU 6 × 7 afterwards → lo = 42, hi = 0.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bundle between decode and the multiply/divide unit.
//
// Request/stall semantics: a request (md_start, mf_req, mt_hi, mt_lo) is
// taken on a rising edge only when stall is low in that cycle. While stall
// is high the requester holds every request field unchanged and re-presents
// it until stall drops. MFHI/MFLO read hi/lo directly; there is no transfer.
//
// Signals:
//   md_start/md_op/md_a/md_b  multiply/divide issue (op 00 MULT, 01 MULTU,
//                             10 DIV, 11 DIVU)
//   mf_req                    MFHI/MFLO present this cycle
//   mt_hi/mt_lo/mt_data       MTHI/MTLO write request and data
//   hi/lo                     architectural HI/LO registers
//   busy                      engine not idle
//   stall                     freeze fetch/decode (combinational)
//   state                     engine state for debug/checkers (0 IDLE, 1 ITER, 2 FIX)
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             md_start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             mf_req;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic [1:0]       state;

  modport master (
    output md_start, md_op, md_a, md_b, mf_req, mt_hi, mt_lo, mt_data,
    input  hi, lo, busy, stall, state
  );

  modport slave (
    input  md_start, md_op, md_a, md_b, mf_req, mt_hi, mt_lo, mt_data,
    output hi, lo, busy, stall, state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine and HI/LO register owner.
//
// Runs one shift-add (multiply) or restoring-divide step per cycle for WIDTH
// cycles on operand magnitudes, then applies sign correction in a FIX cycle
// and writes HI/LO. Latency is WIDTH + 1 cycles after the accept edge.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  muldiv_if.slave: requests in; hi, lo, busy, stall, state out
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier being shifted out / dividend shifting into quotient.
  logic [2*WIDTH-1:0] acc;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Issue-time operand preparation
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_signed = ~bus.md_op[0];
    a_neg     = op_signed & bus.md_a[WIDTH-1];
    b_neg     = op_signed & bus.md_b[WIDTH-1];
    a_mag     = a_neg ? (~bus.md_a + 1'b1) : bus.md_a;
    b_mag     = b_neg ? (~bus.md_b + 1'b1) : bus.md_b;
  end

  // One iteration step for each operation
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh - {1'b0, operand};
    // Borrow out of the trial subtract means the divisor did not fit.
    if (div_diff[WIDTH])
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    // Division by zero: the restoring loop already yields an all-ones
    // quotient and a remainder of |a|; skipping the quotient negate keeps
    // lo all-ones, and the remainder sign fix turns |a| back into raw md_a.
    quot_fix = (neg_res & ~div_zero) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // The signed-overflow case (MIN / -1) needs no special path: |MIN| = MIN
  // as an unsigned magnitude, both signs are negative so no negate happens,
  // giving quotient MIN and remainder 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.md_start) begin
            is_div   <= bus.md_op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg & bus.md_op[1];
            div_zero <= bus.md_op[1] & (bus.md_b == '0);
            operand  <= bus.md_op[1] ? b_mag : a_mag;
            acc      <= bus.md_op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            count    <= '0;
            state    <= S_ITER;
          end else begin
            // md_start wins; an MT in the same cycle is dropped.
            if (bus.mt_hi) hi_q <= bus.mt_data;
            if (bus.mt_lo) lo_q <= bus.mt_data;
          end
        end
        S_ITER: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != S_IDLE);
  assign bus.stall = bus.busy & (bus.md_start | bus.mf_req | bus.mt_hi | bus.mt_lo);
  assign bus.state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic void add_vec(input string name, input logic [1:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp_hi = eh; v.exp_lo = el;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.md_start = 1'b0;
    bus.md_op    = 2'b00;
    bus.md_a     = '0;
    bus.md_b     = '0;
    bus.mf_req   = 1'b0;
    bus.mt_hi    = 1'b0;
    bus.mt_lo    = 1'b0;
    bus.mt_data  = '0;
  endtask

  // Presents an operation for one accept edge, then counts busy cycles
  // sampled on negedges until the engine returns to idle (bounded).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cycles);
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    @(posedge clk);
    #1 bus.md_start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      else break;
    end
  endtask

  // Waits for busy to drop; returns 1 on success within the cycle budget.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    int  cyc;
    bit  ok;
    int  stall_cnt;
    logic [W-1:0] e_hi, e_lo;

    idle_inputs();
    // Requests held during reset must not produce stall.
    bus.md_start = 1'b1;
    bus.mf_req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_stall", {31'b0, bus.stall}, 32'h0);
    check("reset_state", {30'b0, bus.state}, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    add_vec("multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    add_vec("mult_m3x5",     OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    add_vec("div_m7d2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec("div_overflow",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add_vec("divu_9d0",      OP_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF);
    add_vec("div_m9d0",      OP_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);
    add_vec("div_7dm2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    add_vec("mult_min_sq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add_vec("mult_neg1",     OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988);
    add_vec("divu_max_d10",  OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999);
    add_vec("multu_2p16sq",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    add_vec("divu_100d7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_hi);
      exp_q.push_back(vecs[i].exp_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      e_hi = exp_q.pop_front();
      e_lo = exp_q.pop_front();
      check({vecs[i].name, "_hi"}, bus.hi, e_hi);
      check({vecs[i].name, "_lo"}, bus.lo, e_lo);
      check({vecs[i].name, "_busy_cycles"}, cyc, 32'd33);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // ---- stall with mf_req held, and back-to-back md_start accepted at E34 ----
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = OP_DIVU;
    bus.md_a     = 32'd100;
    bus.md_b     = 32'd7;
    @(posedge clk);                       // E0
    #1;
    bus.md_op  = OP_MULTU;                // second op held while busy
    bus.md_a   = 32'd3;
    bus.md_b   = 32'd4;
    bus.mf_req = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 10) begin
        check("iter_hi_kept", bus.hi, 32'd2);
        check("iter_state", {30'b0, bus.state}, 32'd1);
      end
      if (bus.stall) stall_cnt++;
      else break;
    end
    check("stall_cycles", stall_cnt, 32'd33);
    check("after_e33_busy", {31'b0, bus.busy}, 32'h0);
    check("divu_100d7_seq_hi", bus.hi, 32'd2);
    check("divu_100d7_seq_lo", bus.lo, 32'd14);
    @(posedge clk);                       // E34
    #1;
    check("b2b_accept_busy", {31'b0, bus.busy}, 32'h1);
    bus.md_start = 1'b0;
    bus.mf_req   = 1'b0;
    @(negedge clk);
    check("b2b_lo_kept", bus.lo, 32'd14);
    wait_idle(ok);
    check("b2b_done", {31'b0, ok}, 32'h1);
    check("b2b_multu_hi", bus.hi, 32'd0);
    check("b2b_multu_lo", bus.lo, 32'd12);

    // ---- md_start wins over mt_lo in the same cycle ----
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = OP_MULTU;
    bus.md_a     = 32'd2;
    bus.md_b     = 32'd3;
    bus.mt_lo    = 1'b1;
    bus.mt_data  = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.md_start = 1'b0;
    bus.mt_lo    = 1'b0;
    check("mt_dropped_lo", bus.lo, 32'd12);
    wait_idle(ok);
    check("mt_drop_done", {31'b0, ok}, 32'h1);
    check("mt_drop_result_lo", bus.lo, 32'd6);

    // ---- MTLO, then MTHI+MTLO together ----
    @(negedge clk);
    bus.mt_lo   = 1'b1;
    bus.mt_data = 32'h1234;
    @(posedge clk);
    #1 bus.mt_lo = 1'b0;
    check("mtlo_lo", bus.lo, 32'h1234);
    check("mtlo_hi_kept", bus.hi, 32'h0);
    @(negedge clk);
    bus.mt_hi   = 1'b1;
    bus.mt_lo   = 1'b1;
    bus.mt_data = 32'hA5A5;
    @(posedge clk);
    #1;
    bus.mt_hi = 1'b0;
    bus.mt_lo = 1'b0;
    check("mtboth_hi", bus.hi, 32'hA5A5);
    check("mtboth_lo", bus.lo, 32'hA5A5);

    // ---- MTHI while busy is stalled and not written ----
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = OP_MULTU;
    bus.md_a     = 32'd1;
    bus.md_b     = 32'd1;
    @(posedge clk);
    #1 bus.md_start = 1'b0;
    @(negedge clk);
    bus.mt_hi   = 1'b1;
    bus.mt_data = 32'h0BAD;
    #1 check("mt_busy_stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clk);
    #1 bus.mt_hi = 1'b0;
    check("mt_busy_hi_kept", bus.hi, 32'hA5A5);
    wait_idle(ok);
    check("mt_busy_done", {31'b0, ok}, 32'h1);
    check("mt_busy_result_hi", bus.hi, 32'd0);
    check("mt_busy_result_lo", bus.lo, 32'd1);

    // ---- async reset mid-MULT ----
    @(negedge clk);
    bus.mt_lo   = 1'b1;
    bus.mt_data = 32'h5555;
    @(posedge clk);
    #1 bus.mt_lo = 1'b0;
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = OP_MULT;
    bus.md_a     = 32'hFFFFFFFD;
    bus.md_b     = 32'd5;
    @(posedge clk);                       // E0
    #1 bus.md_start = 1'b0;
    repeat (10) @(posedge clk);           // E10
    #2;
    rst = 1'b1;
    bus.mf_req = 1'b1;
    #1;
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.mf_req = 1'b0;
    run_op(OP_MULTU, 32'd6, 32'd7, cyc);
    check("post_reset_hi", bus.hi, 32'd0);
    check("post_reset_lo", bus.lo, 32'd42);
    check("post_reset_busy_cycles", cyc, 32'd33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
